// File: rtl/jk_bank_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the JK register-bank controller.
package jk_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_UP     = 2'b01,
        OP_DOWN   = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/jk_bank_ctrl_jk_cell.sv
// One JK flip-flop built on a D flop: D = J&~Q | ~K&Q.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= 1'b0;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command FSM driving a bank of JK cells: load, count up/down by N, toggle mask.
module jk_bank_ctrl
    import jk_bank_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q, ready_q;
    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] t;
    logic             carry;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d   = op_e'(cmd_op);
                    data_d = cmd_data;
                    if (cmd_op == OP_LOAD || cmd_op == OP_TOGGLE) begin
                        cnt_d   = WIDTH'(1);
                        state_d = RUN;
                    end else if (cmd_data == '0) begin
                        // A zero-step count skips RUN entirely
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cmd_data;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - WIDTH'(1);
                if (cnt_q == WIDTH'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counting uses the ripple-toggle form: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        j     = '0;
        k     = '0;
        t     = '0;
        carry = 1'b1;
        if (state_q == RUN) begin
            case (op_q)
                OP_LOAD: begin
                    j = data_q;
                    k = ~data_q;
                end
                OP_TOGGLE: begin
                    j = data_q;
                    k = data_q;
                end
                OP_UP: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        t[i]  = carry;
                        carry = carry & q[i];
                    end
                    j = t;
                    k = t;
                end
                OP_DOWN: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        t[i]  = carry;
                        carry = carry & ~q[i];
                    end
                    j = t;
                    k = t;
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            ready_q <= (state_d == IDLE);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[g]),
            .k   (k[g]),
            .q   (q[g])
        );
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl: stimulus queues expected steps/completions, a monitor checks them.
module tb_jk_bank_ctrl;
    import jk_bank_ctrl_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_ready;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] qv;
        int           runs;
    } done_t;

    logic [W-1:0] step_q[$];
    done_t        done_exp[$];
    bit           mon_en = 1'b1;

    jk_bank_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_step(input logic [W-1:0] v);
        step_q.push_back(v);
    endtask

    task automatic push_done(input logic [W-1:0] v, input int runs);
        done_t e;
        e.qv   = v;
        e.runs = runs;
        done_exp.push_back(e);
    endtask

    // Monitor: an edge that ended a RUN cycle must produce the next queued step value
    initial begin : monitor
        bit    prev_run;
        bit    prev_done;
        int    runs;
        done_t e;
        prev_run  = 1'b0;
        prev_done = 1'b0;
        runs      = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_run  = 1'b0;
                prev_done = 1'b0;
                runs      = 0;
            end else begin
                if (mon_en) begin
                    if (prev_done) chk("ready_after_done", {31'b0, cmd_ready}, 32'd1);
                    if (prev_run) begin
                        if (step_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_step: got q=%0h expected no step", q);
                        end else begin
                            chk("step_q", {28'b0, q}, {28'b0, step_q.pop_front()});
                        end
                    end
                    if (done) begin
                        if (done_exp.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_done: got done=1 expected none");
                        end else begin
                            e = done_exp.pop_front();
                            chk("done_q", {28'b0, q}, {28'b0, e.qv});
                            chk("run_cycles", runs, e.runs);
                        end
                    end
                end
                if (busy && !done) runs++;
                if (done) runs = 0;
                prev_run  = busy && !done;
                prev_done = done;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [W-1:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=0 expected 1");
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit got_done;
        #2 rst = 1'b0;
        #1;
        chk("rst_q", {28'b0, q}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        push_step(4'b1010); push_done(4'b1010, 1);
        send(OP_LOAD, 4'b1010); wait_done();

        push_step(4'b1101); push_done(4'b1101, 1);
        send(OP_LOAD, 4'b1101); wait_done();
        push_step(4'b1110); push_step(4'b1111); push_step(4'b0000);
        push_step(4'b0001); push_step(4'b0010); push_done(4'b0010, 5);
        send(OP_UP, 4'd5); wait_done();

        push_step(4'b0001); push_done(4'b0001, 1);
        send(OP_LOAD, 4'b0001); wait_done();
        push_step(4'b0000); push_step(4'b1111); push_step(4'b1110);
        push_done(4'b1110, 3);
        send(OP_DOWN, 4'd3); wait_done();

        push_step(4'b0110); push_done(4'b0110, 1);
        send(OP_LOAD, 4'b0110); wait_done();
        push_step(4'b0101); push_done(4'b0101, 1);
        send(OP_TOGGLE, 4'b0011); wait_done();
        push_done(4'b0101, 0);
        send(OP_UP, 4'd0); wait_done();

        // cmd_valid stays high with shifting op/data while the count runs
        push_step(4'b0110); push_step(4'b0111); push_step(4'b1000); push_step(4'b1001);
        push_done(4'b1001, 4);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_UP;
        cmd_data  = 4'd4;
        @(posedge clk);
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                cmd_valid = 1'b0;
                got_done  = 1'b1;
                break;
            end
            chk("ready_while_busy", {31'b0, cmd_ready}, 32'd0);
            cmd_op   = 2'(i);
            cmd_data = W'(i * 3 + 1);
        end
        cmd_valid = 1'b0;
        if (!got_done) begin
            total++;
            bad++;
            $display("FAIL hold_done_timeout: got done=0 expected 1");
        end
        repeat (2) @(negedge clk);
        chk("hold_final_q", {28'b0, q}, {28'b0, 4'b1001});
        chk("hold_idle_busy", {31'b0, busy}, 32'd0);

        mon_en = 1'b0;
        send(OP_UP, 4'd8);
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_q", {28'b0, q}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", {31'b0, done}, 32'd0);
        end
        mon_en = 1'b1;
        push_step(4'b0111); push_done(4'b0111, 1);
        send(OP_LOAD, 4'b0111); wait_done();

        repeat (3) @(negedge clk);
        chk("steps_left", step_q.size(), 32'd0);
        chk("dones_left", done_exp.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
